pc_ras_unit: RTL and testbench



---
 rtl/mycpu_pkg.sv | 17 +
 rtl/pc_ras.sv | 68 ++++++
 rtl/pc_ras_unit.sv | 92 +++++++++
 tb/tb_pc_ras_unit.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// Shared types and defaults for the mycpu core: PC operation encoding and default widths.
package mycpu_pkg;

    localparam int unsigned PC_W_DEF = 16;

    typedef enum logic [2:0] {
        PC_HOLD  = 3'b000,
        PC_INC   = 3'b001,
        PC_BRA   = 3'b010,
        PC_JMP   = 3'b011,
        PC_CALL  = 3'b100,
        PC_RET   = 3'b101,
        PC_CALLR = 3'b110,
        PC_RSVD  = 3'b111
    } pc_op_t;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push while full overwrites the oldest entry.
module pc_ras
    import mycpu_pkg::*;
#(
    parameter int unsigned PC_W      = PC_W_DEF,
    parameter int unsigned RAS_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top_data,
    output logic            empty,
    output logic            full,
    output logic            ovf_evt,
    output logic            udf_evt
);

    localparam int unsigned PtrW = $clog2(RAS_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);
    localparam logic [CntW-1:0] CntMax = CntW'(RAS_DEPTH);

    logic [PC_W-1:0] mem_q [RAS_DEPTH];
    logic [PtrW-1:0] wptr_q, wptr_d, top_idx;
    logic [CntW-1:0] count_q, count_d;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CntMax);
    assign top_idx  = wptr_q - PtrOne;
    assign top_data = mem_q[top_idx];
    assign ovf_evt  = push & full;
    assign udf_evt  = pop & empty;

    always_comb begin
        wptr_d  = wptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = wptr_q + PtrOne;
            if (!full) begin
                count_d = count_q + CntOne;
            end
        end else if (pop && !empty) begin
            wptr_d  = top_idx;
            count_d = count_q - CntOne;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; entries are only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/pc_ras_unit.sv
// Next-PC generator: PC register, op decode, next-PC mux, RAS and sticky stack error flags.
module pc_ras_unit
    import mycpu_pkg::*;
#(
    parameter int unsigned     PC_W      = PC_W_DEF,
    parameter int unsigned     RAS_DEPTH = 8,
    parameter logic [PC_W-1:0] RST_VEC   = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_in,
    input  logic [2:0]      op_in,
    input  logic [PC_W-1:0] ia_in,
    input  logic [PC_W-1:0] ra_in,
    input  logic            clr_err_in,
    output logic [PC_W-1:0] pc_out,
    output logic            ras_empty_out,
    output logic            ras_full_out,
    output logic            ras_ovf_out,
    output logic            ras_udf_out
);

    logic [PC_W-1:0] pc_q, pc_d, pc_inc, pc_rel, top_data;
    logic            push, pop, empty, full, ovf_evt, udf_evt;
    logic            ovf_q, udf_q;

    assign pc_inc = pc_q + PC_W'(1);
    assign pc_rel = pc_q + ia_in;

    always_comb begin
        pc_d = pc_q;
        push = 1'b0;
        pop  = 1'b0;
        if (en_in) begin
            case (pc_op_t'(op_in))
                PC_INC:   pc_d = pc_inc;
                PC_BRA:   pc_d = pc_rel;
                PC_JMP:   pc_d = ra_in;
                PC_CALL: begin
                    push = 1'b1;
                    pc_d = ra_in;
                end
                PC_RET: begin
                    pop  = 1'b1;
                    // Empty stack falls through to the next sequential PC.
                    pc_d = empty ? pc_inc : top_data;
                end
                PC_CALLR: begin
                    push = 1'b1;
                    pc_d = pc_rel;
                end
                default:  pc_d = pc_q;
            endcase
        end
    end

    pc_ras #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top_data  (top_data),
        .empty     (empty),
        .full      (full),
        .ovf_evt   (ovf_evt),
        .udf_evt   (udf_evt)
    );

    // A set event in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q  <= RST_VEC;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= (ovf_q & ~clr_err_in) | ovf_evt;
            udf_q <= (udf_q & ~clr_err_in) | udf_evt;
        end
    end

    assign pc_out        = pc_q;
    assign ras_empty_out = empty;
    assign ras_full_out  = full;
    assign ras_ovf_out   = ovf_q;
    assign ras_udf_out   = udf_q;

endmodule

// File: tb/tb_pc_ras_unit.sv
// Scoreboard bench for pc_ras_unit: directed ops push expected state, a negedge monitor compares.
module tb_pc_ras_unit;
    import mycpu_pkg::*;

    localparam int unsigned PC_W = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en_in = 1'b0;
    logic [2:0]      op_in = 3'b000;
    logic [PC_W-1:0] ia_in = '0;
    logic [PC_W-1:0] ra_in = '0;
    logic            clr_err_in = 1'b0;
    logic [PC_W-1:0] pc_out;
    logic            ras_empty_out, ras_full_out, ras_ovf_out, ras_udf_out;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [3:0]      flags; // {empty, full, ovf, udf}
        logic [7:0]      id;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    always #5 clk = ~clk;

    pc_ras_unit #(
        .PC_W      (PC_W),
        .RAS_DEPTH (4),
        .RST_VEC   (16'h0100)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en_in         (en_in),
        .op_in         (op_in),
        .ia_in         (ia_in),
        .ra_in         (ra_in),
        .clr_err_in    (clr_err_in),
        .pc_out        (pc_out),
        .ras_empty_out (ras_empty_out),
        .ras_full_out  (ras_full_out),
        .ras_ovf_out   (ras_ovf_out),
        .ras_udf_out   (ras_udf_out)
    );

    // Monitor: the DUT presents new state after every edge; compare on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [3:0] act_flags;
            e = exp_q.pop_front();
            act_flags = {ras_empty_out, ras_full_out, ras_ovf_out, ras_udf_out};
            checks++;
            if (pc_out !== e.pc || act_flags !== e.flags) begin
                errors++;
                $display("FAIL step%0d: pc=%h flags(e,f,o,u)=%b, required pc=%h flags=%b",
                         e.id, pc_out, act_flags, e.pc, e.flags);
            end
        end
    end

    task automatic step(input pc_op_t op, input logic [PC_W-1:0] ia, input logic [PC_W-1:0] ra,
                        input logic [PC_W-1:0] epc, input logic [3:0] eflags,
                        input logic en = 1'b1, input logic clr = 1'b0, input logic rst = 1'b1);
        exp_t e;
        op_in      = op;
        ia_in      = ia;
        ra_in      = ra;
        en_in      = en;
        clr_err_in = clr;
        rst_n      = rst;
        @(posedge clk);
        e.pc    = epc;
        e.flags = eflags;
        e.id    = 8'(step_id);
        step_id++;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        // Reset held two cycles, op ignored
        step(PC_CALL, 16'h0000, 16'h0700, 16'h0100, 4'b1000, 1'b1, 1'b0, 1'b0);
        step(PC_INC,  16'h0000, 16'h0000, 16'h0100, 4'b1000, 1'b1, 1'b0, 1'b0);
        step(PC_INC,  16'h0000, 16'h0000, 16'h0101, 4'b1000);
        step(PC_INC,  16'h0000, 16'h0000, 16'h0102, 4'b1000);
        step(PC_INC,  16'h0000, 16'h0000, 16'h0103, 4'b1000);
        // Wrap and relative branch
        step(PC_JMP,  16'h0000, 16'hFFFF, 16'hFFFF, 4'b1000);
        step(PC_INC,  16'h0000, 16'h0000, 16'h0000, 4'b1000);
        step(PC_JMP,  16'h0000, 16'h0010, 16'h0010, 4'b1000);
        step(PC_BRA,  16'hFFF0, 16'h0000, 16'h0000, 4'b1000);
        step(PC_JMP,  16'h0000, 16'h0001, 16'h0001, 4'b1000);
        step(PC_BRA,  16'hFFFE, 16'h0000, 16'hFFFF, 4'b1000);
        // Nested call / return
        step(PC_JMP,  16'h0000, 16'h0020, 16'h0020, 4'b1000);
        step(PC_CALL, 16'h0000, 16'h0300, 16'h0300, 4'b0000);
        step(PC_CALLR,16'h0010, 16'h0000, 16'h0310, 4'b0000);
        step(PC_RET,  16'h0000, 16'h0000, 16'h0301, 4'b0000);
        step(PC_RET,  16'h0000, 16'h0000, 16'h0021, 4'b1000);
        step(PC_RSVD, 16'h0004, 16'h0555, 16'h0021, 4'b1000);
        // Overflow with depth 4
        step(PC_JMP,  16'h0000, 16'h0010, 16'h0010, 4'b1000);
        step(PC_CALL, 16'h0000, 16'h0020, 16'h0020, 4'b0000);
        step(PC_CALL, 16'h0000, 16'h0030, 16'h0030, 4'b0000);
        step(PC_CALL, 16'h0000, 16'h0040, 16'h0040, 4'b0000);
        step(PC_CALL, 16'h0000, 16'h0050, 16'h0050, 4'b0100);
        step(PC_CALL, 16'h0000, 16'h0060, 16'h0060, 4'b0110);
        step(PC_RET,  16'h0000, 16'h0000, 16'h0051, 4'b0010);
        step(PC_RET,  16'h0000, 16'h0000, 16'h0041, 4'b0010);
        step(PC_RET,  16'h0000, 16'h0000, 16'h0031, 4'b0010);
        step(PC_RET,  16'h0000, 16'h0000, 16'h0021, 4'b1010);
        step(PC_RET,  16'h0000, 16'h0000, 16'h0022, 4'b1011);
        // Stall with one entry on the stack, then clear during stall
        step(PC_CALL, 16'h0000, 16'h0200, 16'h0200, 4'b0011);
        for (int i = 0; i < 3; i++) begin
            step(PC_CALL, 16'h0000, 16'h0500, 16'h0200, 4'b0011, 1'b0);
        end
        step(PC_CALL, 16'h0000, 16'h0500, 16'h0200, 4'b0000, 1'b0, 1'b1);
        step(PC_RET,  16'h0000, 16'h0000, 16'h0023, 4'b1000);
        // Clear coincident with an underflow: set wins
        step(PC_RET,  16'h0000, 16'h0000, 16'h0024, 4'b1001, 1'b1, 1'b1);
        step(PC_HOLD, 16'h0000, 16'h0000, 16'h0024, 4'b1000, 1'b1, 1'b1);
        // Mid-operation reset
        step(PC_CALL, 16'h0000, 16'h0400, 16'h0400, 4'b0000);
        step(PC_CALL, 16'h0000, 16'h0410, 16'h0410, 4'b0000);
        step(PC_CALL, 16'h0000, 16'h0420, 16'h0420, 4'b0000);
        step(PC_CALL, 16'h0000, 16'h0700, 16'h0100, 4'b1000, 1'b1, 1'b0, 1'b0);
        step(PC_RET,  16'h0000, 16'h0000, 16'h0101, 4'b1001);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
